// File: rtl/hid_key_event_fifo.sv
// Purpose: diff keyboard report snapshots into ordered make/break events and queue them for the SPI reader.
// Latency: a report sampled at edge N can push its first event at edge N+1; every scan takes exactly 17 cycles.
// Backpressure: none upstream. One report waits in a pending slot; pushes into a full queue are dropped and set ovf.
module hid_key_event_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk12,
    input  logic                     rst_n,
    input  logic                     conn,
    input  logic                     kbd_report,
    input  logic [7:0]               kbd_mod,
    input  logic [7:0]               kbd_key1,
    input  logic [7:0]               kbd_key2,
    input  logic [7:0]               kbd_key3,
    input  logic [7:0]               kbd_key4,
    input  logic                     pop,
    input  logic                     flush,
    output logic                     evt_valid,
    output logic [8:0]               evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     ovf,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_MOD, S_BRK, S_MAK, S_COMMIT} state_t;

    state_t          r_state, w_state_nxt;
    logic [2:0]      r_step, w_step_nxt;
    logic [7:0]      r_cur_mod, r_prev_mod, r_pend_mod;
    logic [3:0][7:0] r_cur_key, r_prev_key, r_pend_key;
    logic            r_pend_vld;
    logic [3:0][7:0] w_in_key;
    logic            w_rollover;
    logic [1:0]      w_step2;
    logic [7:0]      w_key;
    logic            w_hit;
    logic            w_push;
    logic [8:0]      w_push_dat;
    logic            w_pend_ovf;

    logic [8:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_full, w_do_pop, w_do_push, w_drop;

    assign w_in_key   = {kbd_key4, kbd_key3, kbd_key2, kbd_key1};
    assign w_step2    = r_step[1:0];
    assign w_rollover = (r_cur_key[0] == 8'h01) || (r_cur_key[1] == 8'h01) ||
                        (r_cur_key[2] == 8'h01) || (r_cur_key[3] == 8'h01);
    // A report landing while a scan runs (other than its last cycle) replaces a still-waiting one.
    assign w_pend_ovf = conn && kbd_report && r_pend_vld &&
                        (r_state != S_IDLE) && (r_state != S_COMMIT);

    // Scan sequencer state and step counter.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
        end
    end

    // Next state: 8 modifier steps, 4 break steps, 4 make steps, one commit; disconnect aborts.
    always_comb begin
        w_state_nxt = r_state;
        w_step_nxt  = r_step;
        case (r_state)
            S_IDLE: begin
                if (kbd_report) begin
                    w_state_nxt = S_MOD;
                    w_step_nxt  = 3'd0;
                end
            end
            S_MOD: begin
                w_step_nxt = r_step + 3'd1;
                if (r_step == 3'd7) begin
                    w_state_nxt = S_BRK;
                    w_step_nxt  = 3'd0;
                end
            end
            S_BRK: begin
                w_step_nxt = r_step + 3'd1;
                if (r_step == 3'd3) begin
                    w_state_nxt = S_MAK;
                    w_step_nxt  = 3'd0;
                end
            end
            S_MAK: begin
                w_step_nxt = r_step + 3'd1;
                if (r_step == 3'd3) begin
                    w_state_nxt = S_COMMIT;
                    w_step_nxt  = 3'd0;
                end
            end
            S_COMMIT: begin
                w_step_nxt  = 3'd0;
                w_state_nxt = (r_pend_vld || kbd_report) ? S_MOD : S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_step_nxt  = 3'd0;
            end
        endcase
        if (!conn) begin
            w_state_nxt = S_IDLE;
            w_step_nxt  = 3'd0;
        end
    end

    // Event generation for the current step; at most one candidate event per cycle.
    always_comb begin
        w_push     = 1'b0;
        w_push_dat = 9'd0;
        w_key      = 8'd0;
        w_hit      = 1'b0;
        case (r_state)
            S_MOD: begin
                w_push     = r_prev_mod[r_step] != r_cur_mod[r_step];
                w_push_dat = {r_cur_mod[r_step], 8'hE0 + {5'd0, r_step}};
            end
            S_BRK: begin
                w_key = r_prev_key[w_step2];
                for (int j = 0; j < 4; j++) begin
                    if (r_cur_key[j] == w_key) w_hit = 1'b1;
                end
                w_push     = !w_rollover && (w_key != 8'd0) && !w_hit;
                w_push_dat = {1'b0, w_key};
            end
            S_MAK: begin
                w_key = r_cur_key[w_step2];
                for (int j = 0; j < 4; j++) begin
                    if (r_prev_key[j] == w_key) w_hit = 1'b1;
                    if ((j < int'(w_step2)) && (r_cur_key[j] == w_key)) w_hit = 1'b1;
                end
                w_push     = !w_rollover && (w_key != 8'd0) && !w_hit;
                w_push_dat = {1'b1, w_key};
            end
            default: begin
                w_push = 1'b0;
            end
        endcase
        if (!conn) w_push = 1'b0;
    end

    // Snapshot registers: current, previous and the one-deep pending slot.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            r_cur_mod  <= 8'd0;
            r_cur_key  <= '0;
            r_prev_mod <= 8'd0;
            r_prev_key <= '0;
            r_pend_mod <= 8'd0;
            r_pend_key <= '0;
            r_pend_vld <= 1'b0;
        end else if (!conn) begin
            r_prev_mod <= 8'd0;
            r_prev_key <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (kbd_report) begin
                        r_cur_mod <= kbd_mod;
                        r_cur_key <= w_in_key;
                    end
                end
                S_COMMIT: begin
                    r_prev_mod <= r_cur_mod;
                    if (!w_rollover) r_prev_key <= r_cur_key;
                    if (r_pend_vld) begin
                        r_cur_mod  <= r_pend_mod;
                        r_cur_key  <= r_pend_key;
                        r_pend_vld <= kbd_report;
                        if (kbd_report) begin
                            r_pend_mod <= kbd_mod;
                            r_pend_key <= w_in_key;
                        end
                    end else if (kbd_report) begin
                        r_cur_mod <= kbd_mod;
                        r_cur_key <= w_in_key;
                    end
                end
                default: begin
                    if (kbd_report) begin
                        r_pend_mod <= kbd_mod;
                        r_pend_key <= w_in_key;
                        r_pend_vld <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign w_full    = r_count == CW'(DEPTH);
    assign w_do_pop  = pop && (r_count != '0);
    assign w_do_push = w_push && (!w_full || w_do_pop);
    assign w_drop    = w_push && w_full && !w_do_pop;

    // Queue pointers and occupancy; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Event storage; stale contents are masked by the occupancy count.
    always_ff @(posedge clk12) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= w_push_dat;
    end

    // Sticky overflow: dropped event or overwritten pending report.
    always_ff @(posedge clk12 or negedge rst_n) begin
        if (!rst_n)                      ovf <= 1'b0;
        else if (flush)                  ovf <= 1'b0;
        else if (w_drop || w_pend_ovf)   ovf <= 1'b1;
    end

    assign evt_valid = r_count != '0;
    assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : 9'd0;
    assign evt_count = r_count;
    assign busy      = r_state != S_IDLE;
endmodule

// File: tb/tb_hid_key_event_fifo.sv
// Bench for hid_key_event_fifo: table of report snapshots with hand-derived events, plus
// sequences for latency, overflow, pending overwrite, disconnect and mid-scan reset.
// Expected events go into a queue as reports are driven and are popped as the DUT presents them.
module tb_hid_key_event_fifo;
    logic       clk12 = 1'b0;
    logic       rst_n = 1'b0;
    logic       conn = 1'b1;
    logic       kbd_report = 1'b0;
    logic [7:0] kbd_mod = 8'd0;
    logic [7:0] kbd_key1 = 8'd0, kbd_key2 = 8'd0, kbd_key3 = 8'd0, kbd_key4 = 8'd0;
    logic       pop = 1'b0;
    logic       flush = 1'b0;
    logic       evt_valid;
    logic [8:0] evt_data;
    logic [4:0] evt_count;
    logic       ovf;
    logic       busy;

    int         n_vec = 0;
    int         n_err = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0]      mod;
        logic [3:0][7:0] key;
        int              n;
        logic [3:0][8:0] ev;
    } vec_t;
    vec_t tbl[13];

    hid_key_event_fifo #(.DEPTH(16)) dut (
        .clk12(clk12), .rst_n(rst_n), .conn(conn), .kbd_report(kbd_report),
        .kbd_mod(kbd_mod), .kbd_key1(kbd_key1), .kbd_key2(kbd_key2),
        .kbd_key3(kbd_key3), .kbd_key4(kbd_key4), .pop(pop), .flush(flush),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_count(evt_count),
        .ovf(ovf), .busy(busy)
    );

    always #5 clk12 = ~clk12;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [7:0] m, input logic [7:0] k1, input logic [7:0] k2,
                           input logic [7:0] k3, input logic [7:0] k4, input int n,
                           input logic [8:0] e0, input logic [8:0] e1, input logic [8:0] e2, input logic [8:0] e3);
        tbl[i].mod = m;
        tbl[i].key = {k4, k3, k2, k1};
        tbl[i].n   = n;
        tbl[i].ev  = {e3, e2, e1, e0};
    endtask

    // One-cycle report pulse; returns on the negedge after the sampling edge.
    task automatic send(input logic [7:0] m, input logic [7:0] k1, input logic [7:0] k2,
                        input logic [7:0] k3, input logic [7:0] k4);
        @(negedge clk12);
        kbd_mod = m; kbd_key1 = k1; kbd_key2 = k2; kbd_key3 = k3; kbd_key4 = k4;
        kbd_report = 1'b1;
        @(negedge clk12);
        kbd_report = 1'b0;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            @(negedge clk12);
            cyc++;
        end
        if (cyc >= 200) check("busy_timeout", 32'(busy), 32'd0);
    endtask

    task automatic pulse_flush();
        @(negedge clk12);
        flush = 1'b1;
        @(negedge clk12);
        flush = 1'b0;
    endtask

    // Compare the queued events against the FIFO head, popping one per cycle.
    task automatic drain();
        logic [8:0] e;
        check("count_before_drain", 32'(evt_count), 32'(exp_q.size()));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("evt_valid_head", 32'(evt_valid), 32'd1);
            check("evt_data", 32'(evt_data), 32'(e));
            pop = 1'b1;
            @(negedge clk12);
            pop = 1'b0;
        end
        check("evt_valid_drained", 32'(evt_valid), 32'd0);
        check("count_drained", 32'(evt_count), 32'd0);
    endtask

    initial begin
        int c;
        set_vec(0,  8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1, 9'h104, 9'h0,   9'h0,   9'h0);
        set_vec(1,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 9'h004, 9'h0,   9'h0,   9'h0);
        set_vec(2,  8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 2, 9'h1E1, 9'h1E5, 9'h0,   9'h0);
        set_vec(3,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2, 9'h0E1, 9'h0E5, 9'h0,   9'h0);
        set_vec(4,  8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 1, 9'h104, 9'h0,   9'h0,   9'h0);
        set_vec(5,  8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 0, 9'h0,   9'h0,   9'h0,   9'h0);
        set_vec(6,  8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 2, 9'h004, 9'h105, 9'h0,   9'h0);
        set_vec(7,  8'h01, 8'h05, 8'h06, 8'h06, 8'h00, 2, 9'h1E0, 9'h106, 9'h0,   9'h0);
        set_vec(8,  8'h00, 8'h06, 8'h07, 8'h00, 8'h05, 2, 9'h0E0, 9'h107, 9'h0,   9'h0);
        set_vec(9,  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3, 9'h006, 9'h007, 9'h005, 9'h0);
        set_vec(10, 8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 1, 9'h1E7, 9'h0,   9'h0,   9'h0);
        set_vec(11, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 0, 9'h0,   9'h0,   9'h0,   9'h0);
        set_vec(12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1, 9'h0E7, 9'h0,   9'h0,   9'h0);

        // Reset state
        repeat (3) @(negedge clk12);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_data",  32'(evt_data),  32'd0);
        check("rst_evt_count", 32'(evt_count), 32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk12);

        // Table of snapshots
        for (int i = 0; i < 13; i++) begin
            for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].ev[j]);
            send(tbl[i].mod, tbl[i].key[0], tbl[i].key[1], tbl[i].key[2], tbl[i].key[3]);
            wait_idle(c);
            check("busy_cycles", 32'(c), 32'd17);
            drain();
        end

        // First push lands one edge after the sampling edge
        send(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        check("latency_pre", 32'(evt_valid), 32'd0);
        @(negedge clk12);
        check("latency_valid", 32'(evt_valid), 32'd1);
        check("latency_data", 32'(evt_data), 32'h1E0);
        exp_q.push_back(9'h1E0);
        wait_idle(c);
        drain();
        exp_q.push_back(9'h0E0);
        send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle(c);
        drain();

        // Overflow: 16 stored, 2 dropped
        for (int i = 0; i < 8; i++) exp_q.push_back(9'h1E0 + 9'(i));
        for (int i = 0; i < 8; i++) exp_q.push_back(9'h0E0 + 9'(i));
        send(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle(c);
        send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle(c);
        send(8'h03, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle(c);
        check("full_count", 32'(evt_count), 32'd16);
        check("full_ovf", 32'(ovf), 32'd1);
        drain();
        check("ovf_sticky", 32'(ovf), 32'd1);
        @(negedge clk12);
        pop = 1'b1;
        @(negedge clk12);
        pop = 1'b0;
        check("pop_empty_count", 32'(evt_count), 32'd0);
        pulse_flush();
        check("flush_ovf", 32'(ovf), 32'd0);
        exp_q.push_back(9'h0E0);
        exp_q.push_back(9'h0E1);
        send(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
        wait_idle(c);
        drain();

        // Pending overwrite: third report replaces the second
        exp_q.push_back(9'h104);
        exp_q.push_back(9'h004);
        exp_q.push_back(9'h106);
        send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        send(8'h00, 8'h05, 8'h00, 8'h00, 8'h00);
        send(8'h00, 8'h06, 8'h00, 8'h00, 8'h00);
        wait_idle(c);
        check("pend_ovf", 32'(ovf), 32'd1);
        drain();
        pulse_flush();
        check("pend_flush_ovf", 32'(ovf), 32'd0);

        // Disconnect mid-scan: two modifier events already queued survive
        exp_q.push_back(9'h1E0);
        exp_q.push_back(9'h1E1);
        exp_q.push_back(9'h104);
        send(8'hFF, 8'h06, 8'h00, 8'h00, 8'h00);
        @(negedge clk12);
        @(negedge clk12);
        conn = 1'b0;
        @(negedge clk12);
        check("conn_abort_busy", 32'(busy), 32'd0);
        check("conn_abort_count", 32'(evt_count), 32'd2);
        send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        check("conn_low_ignored", 32'(busy), 32'd0);
        @(negedge clk12);
        conn = 1'b1;
        send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        wait_idle(c);
        drain();

        // Async reset mid-scan
        send(8'hFF, 8'h04, 8'h00, 8'h00, 8'h00);
        @(negedge clk12);
        @(negedge clk12);
        check("pre_reset_count", 32'(evt_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(evt_valid), 32'd0);
        check("mid_rst_data",  32'(evt_data),  32'd0);
        check("mid_rst_count", 32'(evt_count), 32'd0);
        check("mid_rst_ovf",   32'(ovf),       32'd0);
        check("mid_rst_busy",  32'(busy),      32'd0);
        @(negedge clk12);
        rst_n = 1'b1;
        @(negedge clk12);
        check("post_rst_busy", 32'(busy), 32'd0);
        exp_q.push_back(9'h104);
        send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
        wait_idle(c);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
